dmac_main_ctrl: RTL and testbench
=================================

# dmac_main_ctrl

Control unit of the two-channel DMAC. It accepts peripheral DMA requests and fetches the 4-word channel descriptor over the AHB master port. It then hands the bus to the selected channel, waits for the channel's completion interrupt, and acknowledges the peripheral. It sits directly upstream of the main datapath and drives all of that datapath's select, enable and config-bus control inputs.

## Interface
Parameters:
- None. Descriptor length is fixed at 4 words; offsets are fixed by the datapath at A0/A4/A8/AC.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- DmacReq  in  2  peripheral request lines; bit1 has priority.
- HReady  in  1  AHB ready.
- M_HResp  in  2  AHB response; 2'b00 = OKAY, 2'b01 = ERROR.
- C_config  in  1  channel select from descriptor Ctrl word bit16; 0 = channel 1, 1 = channel 2.
- irq  in  1  transfer-complete from either channel.
- config_write  out  1  config-bus write flag; constant 0, descriptor fetch is read-only.
- config_HTrans  out  2  HTrans during descriptor fetch.
- addr_inc_sel  out  2  descriptor word index 0..3.
- con_sel  out  2  bus owner: 00 = ch1, 01 = ch2, 10 = config; never 11.
- con_en  out  1  latch con_sel in the datapath.
- DmacReq_Reg_en, PeriAddr_reg_en  out  1 each  capture request and peripheral base.
- SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en  out  1 each  descriptor word 0/1/2/3 load.
- channel_en_1, channel_en_2  out  1 each  channel run enables.
- DmacAck  out  2  one-cycle acknowledge to the served peripheral.
- cfg_err  out  1  one-cycle pulse on ERROR during descriptor fetch.

## Operation
- States: IDLE, CFG_ADDR, CFG_DATA, SELECT, XFER, DONE. A 2-bit word counter `wcnt` and a 1-bit `served` hold the accepted request (1 = bit1).
- IDLE → CFG_ADDR on DmacReq != 0:
  - DmacReq_Reg_en and PeriAddr_reg_en are high combinationally in that cycle.
  - `served` = DmacReq[1]; `wcnt` = 0.
- CFG_ADDR:
  - config_HTrans = 2'b10 (NONSEQ), addr_inc_sel = wcnt, con_sel = 10.
  - Holds until HReady = 1, then → CFG_DATA.
- CFG_DATA:
  - config_HTrans = 00 (IDLE), addr_inc_sel = wcnt.
  - HReady = 0: stay.
  - HReady = 1 with M_HResp = OKAY: pulse the register enable selected by wcnt (0 SAddr, 1 DAddr, 2 Trans_sz, 3 Ctrl). wcnt < 3 → wcnt+1, CFG_ADDR. wcnt = 3 → SELECT.
  - HReady = 1 with M_HResp = ERROR: no enable, cfg_err pulse, → IDLE, no ack.
- SELECT (1 cycle): con_sel = C_config ? 01 : 00, con_en = 1. → XFER.
- XFER:
  - Keeps the same con_sel.
  - channel_en_1 = ~C_config, channel_en_2 = C_config.
  - Stays until irq = 1, then → DONE.
- DONE (1 cycle):
  - channel enables low; DmacAck = served ? 10 : 01; con_sel = 10.
  - → IDLE. A request still high in IDLE starts a new service.
- Requests arriving outside IDLE are ignored; no queueing.
- Only one enable of {SAddr, DAddr, Trans_sz, Ctrl, DmacReq, PeriAddr} is high in any cycle.

## Timing
- Reset values:
  - state IDLE, wcnt 0, served 0.
  - con_sel 10, config_HTrans 00, addr_inc_sel 00.
  - All enables, DmacAck and cfg_err 0; config_write 0.
- Outputs are Moore decodes of state/wcnt, except the CFG_DATA register enables and cfg_err (gated by HReady/M_HResp) and the IDLE capture enables (gated by DmacReq).
- Zero-wait latency, with request seen in cycle 0:
  - Capture in cycle 0.
  - Word k address phase in cycle 2k+1; word k enable in cycle 2k+2, so Ctrl_Reg_en is in cycle 8.
  - SELECT in cycle 9; channel_en first high in cycle 10.
- C_config is sampled no earlier than SELECT, one cycle after Ctrl_Reg_en.
- irq in XFER cycle n → DmacAck in cycle n+1 → IDLE in n+2.
- Each wait state on HReady adds exactly one cycle in the state where it occurs.
- Asynchronous rst in any state forces all reset values immediately; no ack or error is emitted for the aborted request.

## Test plan
- Reset mid-XFER: assert rst in XFER → channel_en_1/2 = 0, con_sel = 10 and state IDLE without a clock edge.
- DmacReq = 01, HReady = 1, descriptor Ctrl bit16 = 0:
  - addr_inc_sel sequence 0,1,2,3.
  - Enables in cycles 2, 4, 6, 8.
  - con_sel = 00 with con_en in cycle 9; channel_en_1 from cycle 10.
  - irq at cycle 15 → DmacAck = 01 at cycle 16.
- DmacReq = 11, C_config = 1 → served = bit1; con_sel = 01, channel_en_2 = 1, DmacAck = 10.
- HReady low for 3 cycles in the word-2 data phase → Trans_sz_Reg_en delayed 3 cycles, held with no duplicate pulse; SELECT at cycle 12.
- M_HResp = 01 with HReady = 1 in the word-1 data phase → DAddr_Reg_en stays 0; cfg_err pulses once; IDLE next cycle; DmacAck stays 00.
- DmacReq toggling during XFER is ignored. A request still high after DONE is recaptured in the first IDLE cycle.

Source files
------------

// File: rtl/dmac_main_ctrl.sv
// dmac_main_ctrl: control unit of the two-channel DMAC.
//
// Accepts a peripheral request, fetches the 4-word channel descriptor over
// the AHB master port (one address phase and one data phase per word), hands
// the bus to the channel chosen by the descriptor, waits for that channel's
// completion irq, and acknowledges the peripheral that was served.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   DmacReq[1:0]              peripheral requests, bit1 has priority
//   HReady, M_HResp[1:0]      AHB ready / response for the descriptor fetch
//   C_config                  channel select from descriptor Ctrl bit16
//   irq                       transfer complete from either channel
//   config_write              config-bus write flag (fetch is read-only)
//   config_HTrans[1:0]        HTrans while fetching the descriptor
//   addr_inc_sel[1:0]         descriptor word index
//   con_sel[1:0], con_en      bus owner select (00 ch1, 01 ch2, 10 config)
//   *_Reg_en / *_reg_en       datapath register load enables
//   channel_en_1/2            channel run enables
//   DmacAck[1:0]              one-cycle acknowledge to the served peripheral
//   cfg_err                   one-cycle pulse on an ERROR during the fetch
//
// state    | meaning
// IDLE     | waiting for a request; captures request and peripheral base
// CFG_ADDR | NONSEQ address phase for descriptor word wcnt
// CFG_DATA | data phase for word wcnt; loads its register on OKAY
// SELECT   | latch the channel as bus owner
// XFER     | channel running until irq
// DONE     | acknowledge the served peripheral
module dmac_main_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] DmacReq,
  input  logic       HReady,
  input  logic [1:0] M_HResp,
  input  logic       C_config,
  input  logic       irq,
  output logic       config_write,
  output logic [1:0] config_HTrans,
  output logic [1:0] addr_inc_sel,
  output logic [1:0] con_sel,
  output logic       con_en,
  output logic       DmacReq_Reg_en,
  output logic       PeriAddr_reg_en,
  output logic       SAddr_Reg_en,
  output logic       DAddr_Reg_en,
  output logic       Trans_sz_Reg_en,
  output logic       Ctrl_Reg_en,
  output logic       channel_en_1,
  output logic       channel_en_2,
  output logic [1:0] DmacAck,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    IDLE, CFG_ADDR, CFG_DATA, SELECT, XFER, DONE
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] SEL_CH1       = 2'b00;
  localparam logic [1:0] SEL_CH2       = 2'b01;
  localparam logic [1:0] SEL_CFG       = 2'b10;

  state_t     state, state_nxt;
  logic [1:0] wcnt, wcnt_nxt;
  logic       served, served_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wcnt   <= 2'd0;
      served <= 1'b0;
    end else begin
      state  <= state_nxt;
      wcnt   <= wcnt_nxt;
      served <= served_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    wcnt_nxt        = wcnt;
    served_nxt      = served;
    config_write    = 1'b0;
    config_HTrans   = HTRANS_IDLE;
    addr_inc_sel    = 2'b00;
    con_sel         = SEL_CFG;
    con_en          = 1'b0;
    DmacReq_Reg_en  = 1'b0;
    PeriAddr_reg_en = 1'b0;
    SAddr_Reg_en    = 1'b0;
    DAddr_Reg_en    = 1'b0;
    Trans_sz_Reg_en = 1'b0;
    Ctrl_Reg_en     = 1'b0;
    channel_en_1    = 1'b0;
    channel_en_2    = 1'b0;
    DmacAck         = 2'b00;
    cfg_err         = 1'b0;

    case (state)
      IDLE: begin
        // rst gates the capture enables so nothing is loaded while in reset
        if (DmacReq != 2'b00 && !rst) begin
          DmacReq_Reg_en  = 1'b1;
          PeriAddr_reg_en = 1'b1;
          served_nxt      = DmacReq[1];
          wcnt_nxt        = 2'd0;
          state_nxt       = CFG_ADDR;
        end
      end
      CFG_ADDR: begin
        config_HTrans = HTRANS_NONSEQ;
        addr_inc_sel  = wcnt;
        if (HReady) state_nxt = CFG_DATA;
      end
      CFG_DATA: begin
        addr_inc_sel = wcnt;
        if (HReady) begin
          if (M_HResp == HRESP_OKAY) begin
            case (wcnt)
              2'd0:    SAddr_Reg_en    = 1'b1;
              2'd1:    DAddr_Reg_en    = 1'b1;
              2'd2:    Trans_sz_Reg_en = 1'b1;
              default: Ctrl_Reg_en     = 1'b1;
            endcase
            if (wcnt == 2'd3) begin
              state_nxt = SELECT;
            end else begin
              wcnt_nxt  = wcnt + 2'd1;
              state_nxt = CFG_ADDR;
            end
          end else begin
            // aborted fetch: drop the request without acknowledging it
            cfg_err   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      SELECT: begin
        con_sel   = C_config ? SEL_CH2 : SEL_CH1;
        con_en    = 1'b1;
        state_nxt = XFER;
      end
      XFER: begin
        con_sel      = C_config ? SEL_CH2 : SEL_CH1;
        channel_en_1 = ~C_config;
        channel_en_2 = C_config;
        if (irq) state_nxt = DONE;
      end
      DONE: begin
        DmacAck   = served ? 2'b10 : 2'b01;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmac_main_ctrl.sv
module tb_dmac_main_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] DmacReq = 2'b00;
  logic       HReady = 1'b1;
  logic [1:0] M_HResp = 2'b00;
  logic       C_config = 1'b0;
  logic       irq = 1'b0;

  logic       config_write;
  logic [1:0] config_HTrans, addr_inc_sel, con_sel, DmacAck;
  logic       con_en, DmacReq_Reg_en, PeriAddr_reg_en;
  logic       SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en;
  logic       channel_en_1, channel_en_2, cfg_err;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  dmac_main_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .DmacReq         (DmacReq),
    .HReady          (HReady),
    .M_HResp         (M_HResp),
    .C_config        (C_config),
    .irq             (irq),
    .config_write    (config_write),
    .config_HTrans   (config_HTrans),
    .addr_inc_sel    (addr_inc_sel),
    .con_sel         (con_sel),
    .con_en          (con_en),
    .DmacReq_Reg_en  (DmacReq_Reg_en),
    .PeriAddr_reg_en (PeriAddr_reg_en),
    .SAddr_Reg_en    (SAddr_Reg_en),
    .DAddr_Reg_en    (DAddr_Reg_en),
    .Trans_sz_Reg_en (Trans_sz_Reg_en),
    .Ctrl_Reg_en     (Ctrl_Reg_en),
    .channel_en_1    (channel_en_1),
    .channel_en_2    (channel_en_2),
    .DmacAck         (DmacAck),
    .cfg_err         (cfg_err)
  );

  // observed outputs packed as
  // {con_sel, con_en, HTrans, addr_inc_sel,
  //  SAddr, DAddr, Trans_sz, Ctrl, DmacReq_en, PeriAddr_en,
  //  ch1, ch2, DmacAck, cfg_err, config_write}
  logic [18:0] obs;
  assign obs = {con_sel, con_en, config_HTrans, addr_inc_sel,
                SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en,
                DmacReq_Reg_en, PeriAddr_reg_en,
                channel_en_1, channel_en_2, DmacAck, cfg_err, config_write};

  function automatic logic [18:0] ov(input logic [1:0] cs, input logic ce,
                                     input logic [1:0] ht, input logic [1:0] ais,
                                     input logic [5:0] en, input logic [1:0] ch,
                                     input logic [1:0] ack, input logic err);
    return {cs, ce, ht, ais, en, ch, ack, err, 1'b0};
  endfunction

  function automatic logic [18:0] idle_v(input logic rq);
    return ov(2'b10, 1'b0, 2'b00, 2'b00, rq ? 6'b000011 : 6'b000000, 2'b00, 2'b00, 1'b0);
  endfunction

  function automatic logic [18:0] addr_v(input logic [1:0] k);
    return ov(2'b10, 1'b0, 2'b10, k, 6'b000000, 2'b00, 2'b00, 1'b0);
  endfunction

  function automatic logic [18:0] data_v(input logic [1:0] k, input logic on);
    logic [5:0] en;
    en = on ? (6'b100000 >> k) : 6'b000000;
    return ov(2'b10, 1'b0, 2'b00, k, en, 2'b00, 2'b00, 1'b0);
  endfunction

  function automatic logic [18:0] sel_v(input logic cc);
    return ov(cc ? 2'b01 : 2'b00, 1'b1, 2'b00, 2'b00, 6'b000000, 2'b00, 2'b00, 1'b0);
  endfunction

  function automatic logic [18:0] xfer_v(input logic cc);
    return ov(cc ? 2'b01 : 2'b00, 1'b0, 2'b00, 2'b00, 6'b000000,
              cc ? 2'b01 : 2'b10, 2'b00, 1'b0);
  endfunction

  function automatic logic [18:0] done_v(input logic s);
    return ov(2'b10, 1'b0, 2'b00, 2'b00, 6'b000000, 2'b00, s ? 2'b10 : 2'b01, 1'b0);
  endfunction

  function automatic logic [18:0] err_v(input logic [1:0] k);
    return ov(2'b10, 1'b0, 2'b00, k, 6'b000000, 2'b00, 2'b00, 1'b1);
  endfunction

  // zero-wait fetch expectation for cycle d (1..8) of a service
  function automatic logic [18:0] fetch_v(input int d);
    if (d % 2 == 1) return addr_v(2'((d - 1) / 2));
    else            return data_v(2'((d - 2) / 2), 1'b1);
  endfunction

  task automatic test_reset();
    DmacReq = 2'b11;
    #1 rst = 1'b1;
    #1;
    nvec++;
    if (obs !== idle_v(1'b0)) begin
      nfail++;
      $display("FAIL reset_state: got %b want %b", obs, idle_v(1'b0));
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    DmacReq = 2'b00;
    #1;
    nvec++;
    if (obs !== idle_v(1'b0)) begin
      nfail++;
      $display("FAIL reset_release: got %b want %b", obs, idle_v(1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [18:0] exp;
    for (int c = 0; c <= 17; c++) begin
      DmacReq = (c == 0) ? 2'b01 : 2'b00;
      HReady = 1'b1; M_HResp = 2'b00; C_config = 1'b0; irq = (c == 15);
      if (c == 0)       exp = idle_v(1'b1);
      else if (c <= 8)  exp = fetch_v(c);
      else if (c == 9)  exp = sel_v(1'b0);
      else if (c <= 15) exp = xfer_v(1'b0);
      else if (c == 16) exp = done_v(1'b0);
      else              exp = idle_v(1'b0);
      #1;
      nvec++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL nominal cycle %0d: got %b want %b", c, obs, exp);
      end
      @(negedge clk);
    end
    irq = 1'b0;
  endtask

  task automatic test_prio();
    logic [18:0] exp;
    for (int c = 0; c <= 13; c++) begin
      DmacReq = (c == 0) ? 2'b11 : 2'b00;
      HReady = 1'b1; M_HResp = 2'b00; C_config = (c >= 9); irq = (c == 11);
      if (c == 0)       exp = idle_v(1'b1);
      else if (c <= 8)  exp = fetch_v(c);
      else if (c == 9)  exp = sel_v(1'b1);
      else if (c <= 11) exp = xfer_v(1'b1);
      else if (c == 12) exp = done_v(1'b1);
      else              exp = idle_v(1'b0);
      #1;
      nvec++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL prio_ch2 cycle %0d: got %b want %b", c, obs, exp);
      end
      @(negedge clk);
    end
    irq = 1'b0; C_config = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [18:0] exp;
    for (int c = 0; c <= 15; c++) begin
      DmacReq = (c == 0) ? 2'b01 : 2'b00;
      HReady = !(c >= 6 && c <= 8); M_HResp = 2'b00; C_config = 1'b0; irq = (c == 13);
      if (c == 0)       exp = idle_v(1'b1);
      else if (c <= 5)  exp = fetch_v(c);
      else if (c <= 8)  exp = data_v(2'd2, 1'b0);
      else if (c == 9)  exp = data_v(2'd2, 1'b1);
      else if (c == 10) exp = addr_v(2'd3);
      else if (c == 11) exp = data_v(2'd3, 1'b1);
      else if (c == 12) exp = sel_v(1'b0);
      else if (c == 13) exp = xfer_v(1'b0);
      else if (c == 14) exp = done_v(1'b0);
      else              exp = idle_v(1'b0);
      #1;
      nvec++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL wait_states cycle %0d: got %b want %b", c, obs, exp);
      end
      @(negedge clk);
    end
    irq = 1'b0; HReady = 1'b1;
  endtask

  task automatic test_error();
    logic [18:0] exp;
    for (int c = 0; c <= 7; c++) begin
      DmacReq = (c == 0) ? 2'b01 : 2'b00;
      HReady = 1'b1; M_HResp = (c == 4) ? 2'b01 : 2'b00; C_config = 1'b0; irq = 1'b0;
      if (c == 0)      exp = idle_v(1'b1);
      else if (c <= 3) exp = fetch_v(c);
      else if (c == 4) exp = err_v(2'd1);
      else             exp = idle_v(1'b0);
      #1;
      nvec++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL cfg_error cycle %0d: got %b want %b", c, obs, exp);
      end
      @(negedge clk);
    end
    M_HResp = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [18:0] exp;
    logic [1:0]  toggles [3];
    toggles[0] = 2'b01; toggles[1] = 2'b11; toggles[2] = 2'b00;
    for (int c = 0; c <= 26; c++) begin
      if (c <= 9)                  DmacReq = 2'b10;
      else if (c <= 12)            DmacReq = toggles[c - 10];
      else if (c == 13)            DmacReq = 2'b10;
      else if (c == 14)            DmacReq = 2'b01;
      else                         DmacReq = 2'b00;
      HReady = 1'b1; M_HResp = 2'b00; C_config = 1'b0; irq = (c == 12 || c == 24);
      if (c == 0)       exp = idle_v(1'b1);
      else if (c <= 8)  exp = fetch_v(c);
      else if (c == 9)  exp = sel_v(1'b0);
      else if (c <= 12) exp = xfer_v(1'b0);
      else if (c == 13) exp = done_v(1'b1);
      else if (c == 14) exp = idle_v(1'b1);
      else if (c <= 22) exp = fetch_v(c - 14);
      else if (c == 23) exp = sel_v(1'b0);
      else if (c == 24) exp = xfer_v(1'b0);
      else if (c == 25) exp = done_v(1'b0);
      else              exp = idle_v(1'b0);
      #1;
      nvec++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", c, obs, exp);
      end
      @(negedge clk);
    end
    irq = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    logic [18:0] exp;
    for (int c = 0; c <= 11; c++) begin
      DmacReq = (c == 0) ? 2'b01 : 2'b00;
      HReady = 1'b1; M_HResp = 2'b00; C_config = 1'b0; irq = 1'b0;
      if (c == 0)      exp = idle_v(1'b1);
      else if (c <= 8) exp = fetch_v(c);
      else if (c == 9) exp = sel_v(1'b0);
      else             exp = xfer_v(1'b0);
      #1;
      nvec++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL pre_abort cycle %0d: got %b want %b", c, obs, exp);
      end
      if (c < 11) @(negedge clk);
    end
    // still mid-cycle: no clock edge between these two samples
    DmacReq = 2'b11;
    rst = 1'b1;
    #1;
    nvec++;
    if (obs !== idle_v(1'b0)) begin
      nfail++;
      $display("FAIL async_abort: got %b want %b", obs, idle_v(1'b0));
    end
    @(negedge clk);
    DmacReq = 2'b00;
    rst = 1'b0;
    for (int c = 0; c <= 2; c++) begin
      #1;
      nvec++;
      if (obs !== idle_v(1'b0)) begin
        nfail++;
        $display("FAIL post_abort cycle %0d: got %b want %b", c, obs, idle_v(1'b0));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_prio();
    test_wait_states();
    test_error();
    test_back_to_back();
    test_reset_mid_xfer();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
